// File: rtl/iomem_word_master_pkg.sv
// iomem_word_master_pkg: iomem line types, lane geometry and word-master FSM states
// Shared by every iomem initiator; the line is fixed at 128 bits (four 32-bit lanes).
package iomem_word_master_pkg;
  localparam int BLK_W  = 128;
  localparam int LANES  = BLK_W / 32;
  localparam int LANE_W = $clog2(LANES);
  typedef struct packed {
    logic               valid;
    logic [31:0]        addr;
    logic [BLK_W-1:0]   data;
    logic [BLK_W/8-1:0] rw;
  } iomem_req_t;
  typedef struct packed {
    logic             valid;
    logic             ready;
    logic [BLK_W-1:0] data;
  } iomem_res_t;
  typedef enum logic [1:0] {WM_IDLE, WM_REQ, WM_RSP} wm_state_e;
endpackage

// File: rtl/iomem_lane_steer.sv
// iomem_lane_steer: maps one 32-bit word onto a lane of an iomem line and back
// Ports: i_lane word lane in the line, i_wstrb/i_wdata store strobes and data,
//        i_line line read data; o_rw line byte strobes, o_data replicated store
//        data, o_word the selected lane of i_line.
module iomem_lane_steer
  import iomem_word_master_pkg::*;
#(
  parameter int BLK_SIZE = BLK_W
) (
  input  logic [LANE_W-1:0]     i_lane,
  input  logic [3:0]            i_wstrb,
  input  logic [31:0]           i_wdata,
  input  logic [BLK_SIZE-1:0]   i_line,
  output logic [BLK_SIZE/8-1:0] o_rw,
  output logic [BLK_SIZE-1:0]   o_data,
  output logic [31:0]           o_word
);
  localparam int RW_W = BLK_SIZE / 8;
  assign o_rw   = RW_W'(i_wstrb) << {i_lane, 2'b00};
  assign o_data = {LANES{i_wdata}};
  assign o_word = i_line[{i_lane, 5'b00000} +: 32];
endmodule

// File: rtl/iomem_word_master.sv
// iomem_word_master: turns single 32-bit client loads/stores into iomem line transactions
// Ports: clk_i/rst_i (async, active-high); cli_req_* client request with ready;
//        cli_rsp_* one-cycle response pulse with rdata/err; iomem_req_o/iomem_res_i
//        line bus toward the responder; busy_o high outside IDLE.
// Build option: define IOMEM_TIMEOUT_EN to abandon a REQ after TIMEOUT_CYCLES cycles
// and answer with err=1; otherwise REQ waits forever and err is tied low.
module iomem_word_master
  import iomem_word_master_pkg::*;
#(
  parameter int BLK_SIZE       = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cli_req_valid_i,
  output logic        cli_req_ready_o,
  input  logic [31:0] cli_addr_i,
  input  logic        cli_we_i,
  input  logic [3:0]  cli_wstrb_i,
  input  logic [31:0] cli_wdata_i,
  output logic        cli_rsp_valid_o,
  output logic [31:0] cli_rsp_rdata_o,
  output logic        cli_rsp_err_o,
  output iomem_req_t  iomem_req_o,
  input  iomem_res_t  iomem_res_i,
  output logic        busy_o
);
  wm_state_e             r_state, w_next;
  logic [31:2]           r_addr;
  logic                  r_we;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_wdata, r_rdata;
  logic [BLK_SIZE/8-1:0] w_rw;
  logic [BLK_SIZE-1:0]   w_line;
  logic [31:0]           w_word;
  logic                  w_tmo, w_unused;
  assign w_unused = ^{cli_addr_i[1:0], iomem_res_i.ready, TIMEOUT_CYCLES == 0};
  iomem_lane_steer #(.BLK_SIZE(BLK_SIZE)) u_steer (
    .i_lane  (r_addr[3:2]),
    .i_wstrb (r_wstrb),
    .i_wdata (r_wdata),
    .i_line  (iomem_res_i.data),
    .o_rw    (w_rw),
    .o_data  (w_line),
    .o_word  (w_word)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= WM_IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next          = r_state;
    cli_req_ready_o = 1'b0;
    cli_rsp_valid_o = 1'b0;
    cli_rsp_rdata_o = '0;
    busy_o          = 1'b1;
    iomem_req_o     = '0;
    case (r_state)
      WM_IDLE: begin
        cli_req_ready_o = !rst_i;
        busy_o          = 1'b0;
        // a store with no enabled bytes has nothing to put on the bus
        w_next          = !cli_req_valid_i ? WM_IDLE :
                          (cli_we_i && cli_wstrb_i == 4'h0) ? WM_RSP : WM_REQ;
      end
      WM_REQ: begin
        iomem_req_o.valid = 1'b1;
        iomem_req_o.addr  = {r_addr, 2'b00};
        iomem_req_o.data  = w_line;
        iomem_req_o.rw    = r_we ? w_rw : '0;
        w_next            = (iomem_res_i.valid || w_tmo) ? WM_RSP : WM_REQ;
      end
      WM_RSP: begin
        // bus valid stays low here, giving the responder one idle cycle
        cli_rsp_valid_o = 1'b1;
        cli_rsp_rdata_o = r_rdata;
        w_next          = WM_IDLE;
      end
      default: w_next = WM_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (r_state == WM_IDLE && cli_req_valid_i) begin
      r_addr  <= cli_addr_i[31:2];
      r_we    <= cli_we_i;
      r_wstrb <= cli_wstrb_i;
      r_wdata <= cli_wdata_i;
      r_rdata <= '0;
    end else if (r_state == WM_REQ && iomem_res_i.valid) begin
      r_rdata <= r_we ? '0 : w_word;
    end
`ifdef IOMEM_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_err;
  // counter is zero outside REQ, so it starts from zero on every entry to REQ
  assign w_tmo = (r_state == WM_REQ) && !iomem_res_i.valid &&
                 (r_cnt == 32'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == WM_REQ && !iomem_res_i.valid) ? r_cnt + 32'd1 : '0;
      r_err <= (r_state == WM_IDLE) ? 1'b0 : (r_err | w_tmo);
    end
  assign cli_rsp_err_o = (r_state == WM_RSP) && r_err;
`else
  assign w_tmo         = 1'b0;
  assign cli_rsp_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_iomem_word_master.sv
// tb_iomem_word_master: random and directed load/store traffic against a word-level memory model
module tb_iomem_word_master;
  import iomem_word_master_pkg::*;
  localparam int TMO = 8;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cli_req_valid_i = 1'b0;
  logic        cli_req_ready_o;
  logic [31:0] cli_addr_i = '0;
  logic        cli_we_i = 1'b0;
  logic [3:0]  cli_wstrb_i = '0;
  logic [31:0] cli_wdata_i = '0;
  logic        cli_rsp_valid_o;
  logic [31:0] cli_rsp_rdata_o;
  logic        cli_rsp_err_o;
  iomem_req_t  iomem_req_o;
  iomem_res_t  iomem_res_i;
  logic        busy_o;
  logic [127:0] mem [16];
  logic [31:0]  shadow [64];
  int resp_delay = 0;
  int req_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  iomem_word_master #(.BLK_SIZE(128), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cli_req_valid_i (cli_req_valid_i),
    .cli_req_ready_o (cli_req_ready_o),
    .cli_addr_i      (cli_addr_i),
    .cli_we_i        (cli_we_i),
    .cli_wstrb_i     (cli_wstrb_i),
    .cli_wdata_i     (cli_wdata_i),
    .cli_rsp_valid_o (cli_rsp_valid_o),
    .cli_rsp_rdata_o (cli_rsp_rdata_o),
    .cli_rsp_err_o   (cli_rsp_err_o),
    .iomem_req_o     (iomem_req_o),
    .iomem_res_i     (iomem_res_i),
    .busy_o          (busy_o)
  );

  // responder: answers after resp_delay waiting cycles (0 = same cycle as the request)
  always_comb begin
    iomem_res_i       = '0;
    iomem_res_i.ready = 1'b1;
    iomem_res_i.valid = iomem_req_o.valid && (req_cnt >= resp_delay);
    iomem_res_i.data  = mem[iomem_req_o.addr[7:4]];
  end

  always @(posedge clk_i) begin
    req_cnt <= (iomem_req_o.valid && !iomem_res_i.valid) ? req_cnt + 1 : 0;
    if (iomem_req_o.valid && iomem_res_i.valid)
      for (int b = 0; b < 16; b++)
        if (iomem_req_o.rw[b]) mem[iomem_req_o.addr[7:4]][b*8 +: 8] <= iomem_req_o.data[b*8 +: 8];
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_word(input int w, input logic [31:0] v);
    shadow[w] = v;
    mem[w/4][(w%4)*32 +: 32] <= v;
  endtask

  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] st,
                     input logic [31:0] wd, input int dly, input bit hold);
    bit bus, to;
    int lat, n;
    logic [15:0]  rw;
    logic [31:0]  rd;
    logic [127:0] line;
    bus = !(we && st == 4'h0);
    to  = 1'b0;
`ifdef IOMEM_TIMEOUT_EN
    to  = bus && dly >= TMO;
`endif
    lat  = !bus ? 1 : to ? TMO + 1 : dly + 2;
    rw   = we ? 16'(st) << (4 * a[3:2]) : 16'h0;
    rd   = (we || to) ? 32'h0 : shadow[a[7:2]];
    line = {4{wd}};
    if (we && !to)
      for (int b = 0; b < 4; b++)
        if (st[b]) shadow[a[7:2]][b*8 +: 8] = wd[b*8 +: 8];
    resp_delay = dly;
    @(negedge clk_i);
    check("idle_ready", cli_req_ready_o, 1);
    check("idle_gap", iomem_req_o.valid, 0);
    cli_req_valid_i = 1'b1;
    cli_addr_i      = a;
    cli_we_i        = we;
    cli_wstrb_i     = st;
    cli_wdata_i     = wd;
    @(negedge clk_i);
    cli_req_valid_i = hold;
    cli_addr_i      = $urandom;
    cli_we_i        = 1'($urandom);
    cli_wstrb_i     = 4'($urandom);
    cli_wdata_i     = $urandom;
    n = 1;
    while (!cli_rsp_valid_o && n < 64) begin
      check("req_valid", iomem_req_o.valid, 1);
      check("req_addr", iomem_req_o.addr, {a[31:2], 2'b00});
      check("req_rw", iomem_req_o.rw, rw);
      check("req_data", iomem_req_o.data, line);
      check("req_busy_ready", {busy_o, cli_req_ready_o}, 2'b10);
      @(negedge clk_i);
      n++;
    end
    check("latency", n, lat);
    check("rsp_valid", cli_rsp_valid_o, 1);
    check("rsp_rdata", cli_rsp_rdata_o, rd);
    check("rsp_err", cli_rsp_err_o, to);
    check("rsp_bus_idle", iomem_req_o.valid, 0);
    check("rsp_busy_ready", {busy_o, cli_req_ready_o}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int w = 0; w < 64; w++) put_word(w, $urandom);
    repeat (2) @(negedge clk_i);
    check("rst_ready", cli_req_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rsp", {cli_rsp_valid_o, cli_rsp_rdata_o, cli_rsp_err_o}, 0);
    check("rst_req", iomem_req_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", cli_req_ready_o, 1);
    check("post_rst_busy", busy_o, 0);

    // slow RAM-style load
    put_word(5, 32'hDEADBEEF);
    txn(32'h8000_0014, 1'b0, 4'h0, 32'h0, 16, 1'b0);
    // partial store then readback of the touched word and its neighbours
    txn(32'h8000_0028, 1'b1, 4'b0110, 32'h1122_3344, 3, 1'b0);
    txn(32'h8000_0028, 1'b0, 4'h0, 32'h0, 1, 1'b0);
    txn(32'h8000_0024, 1'b0, 4'h0, 32'h0, 1, 1'b0);
    txn(32'h8000_002C, 1'b0, 4'h0, 32'h0, 2, 1'b0);
    // combinational timer-style responder
    put_word(0, 32'h0000_0009);
    put_word(1, 32'h0000_0005);
    txn(32'h3000_0004, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    // store with no byte enables never reaches the bus
    txn(32'h8000_0030, 1'b1, 4'h0, 32'hFFFF_FFFF, 5, 1'b0);
    txn(32'h8000_0030, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    // back-to-back with the client valid held high
    for (int i = 0; i < 4; i++)
      txn({24'h800000, 8'(i * 20)}, 1'b0, 4'h0, 32'h0, i, i != 3);
`ifdef IOMEM_TIMEOUT_EN
    txn(32'h8000_0008, 1'b0, 4'h0, 32'h0, 1000, 1'b0);
    txn(32'h8000_0008, 1'b0, 4'h0, 32'h0, TMO - 1, 1'b0);
    txn(32'h8000_000C, 1'b1, 4'hF, 32'hA5A5_A5A5, 50, 1'b0);
    txn(32'h8000_000C, 1'b0, 4'h0, 32'h0, 0, 1'b0);
`endif

    // asynchronous reset in the middle of a REQ
    put_word(16, 32'hCAFE_F00D);
    resp_delay = 20;
    @(negedge clk_i);
    cli_req_valid_i = 1'b1;
    cli_addr_i      = 32'h8000_0040;
    cli_we_i        = 1'b0;
    @(negedge clk_i);
    cli_req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("mid_req_valid", iomem_req_o.valid, 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_req", iomem_req_o.valid, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_ready", cli_req_ready_o, 0);
    @(negedge clk_i);
    check("async_rst_rsp", cli_rsp_valid_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_release_ready", cli_req_ready_o, 1);
    repeat (3) begin
      check("rst_no_rsp", cli_rsp_valid_o, 0);
      @(negedge clk_i);
    end

    // random traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic        we;
      logic [3:0]  st;
      a  = $urandom;
      we = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      txn(a, we, st, $urandom, $urandom_range(0, 6), (i != 59) && ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iomem_word_master.md
Name: iomem_word_master

Overview:
- Initiator-side engine for the iomem line interface (iomem_req_t / iomem_res_t, 128-bit lines, 16 byte-strobes).
- Converts single 32-bit load/store requests from a simple client into line-wide iomem transactions.
- Holds each request until the responder asserts valid, then returns the selected word to the client.
- Sits between a non-CPU client (debug module, loader DMA) and the memory/timer responder on the same bus.

Parameters:
- BLK_SIZE, 128, iomem line width in bits; must be 128 (four 32-bit lanes).
- TIMEOUT_CYCLES, 1024, cycles in REQ before abandoning the transaction (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cli_req_valid_i  in  1  client request valid
- cli_req_ready_o  out  1  engine can accept a request
- cli_addr_i  in  32  byte address; bits [1:0] ignored
- cli_we_i  in  1  1 = store, 0 = load
- cli_wstrb_i  in  4  store byte enables within the word
- cli_wdata_i  in  32  store data
- cli_rsp_valid_o  out  1  one-cycle response pulse
- cli_rsp_rdata_o  out  32  load data (0 for stores and errors)
- cli_rsp_err_o  out  1  transaction timed out
- iomem_req_o  out  iomem_req_t  valid/addr/data/rw toward the responder
- iomem_res_i  in  iomem_res_t  valid/ready/data from the responder
- busy_o  out  1  engine not in IDLE

Behaviour:
- Reset (async, rst_i=1):
  - FSM goes to IDLE; all latched fields and the timeout counter clear.
  - Outputs: cli_req_ready_o=0 while reset is asserted, then 1 from the first cycle out of reset. cli_rsp_valid_o=0, rdata=0, err=0, busy_o=0, iomem_req_o all-zero.
  - Reset asserted mid-transaction drops the request and emits no response.
- FSM states: IDLE, REQ, RSP.
  - IDLE: cli_req_ready_o=1. On cli_req_valid_i, latch addr, we, wstrb and wdata.
    - Store with wstrb=0: go straight to RSP, no bus transaction.
    - All other requests: go to REQ.
  - REQ: drive iomem_req_o for as long as the state holds:
    - valid=1
    - addr = {cli_addr[31:2], 2'b00}
    - data = {4{wdata}}
    - rw = load ? 16'h0 : (wstrb << (addr[3:2]*4))
    - All request fields stay stable until iomem_res_i.valid is high. That response may arrive in the same cycle as the request (combinational timer response) or many cycles later (RAM path).
    - On iomem_res_i.valid: capture iomem_res_i.data[addr[3:2]*32 +: 32] for loads, or 0 for stores, then go to RSP.
    - iomem_res_i.ready is ignored.
  - RSP:
    - iomem_req_o.valid=0. This guarantees at least one idle bus cycle between transactions so the responder's delay pipeline can clear.
    - cli_rsp_valid_o=1 for exactly this cycle; the client has no backpressure.
    - Next state: IDLE.
- Latency:
  - Accept to REQ: 1 cycle.
  - Response pulse: 1 cycle after the first cycle in which iomem_res_i.valid is sampled in REQ.
  - Throughput: at most one transaction per (3 + responder latency) cycles.
- busy_o = (state != IDLE).
- The client request is held in registers, so cli_* inputs may change freely once accepted.

Optional Feature:
- IOMEM_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to REQ and increments on each REQ cycle without valid.
  - When it reaches TIMEOUT_CYCLES-1: drop iomem valid, go to RSP with err=1 and rdata=0.
  - A valid arriving in the same cycle as the timeout wins, giving a normal response.
- Undefined: no counter is built; REQ waits indefinitely and cli_rsp_err_o is tied to 0.

Decomposition:
- Existing ceres_param package:
  - iomem_req_t and iomem_res_t, reused unchanged.
  - New localparams for lane count (BLK_SIZE/32) and lane index width.
  - FSM state enum wm_state_e.
- Sub-module iomem_lane_steer (purely combinational):
  - Inputs: addr[3:2], wstrb, wdata, line rdata.
  - Outputs: 16-bit rw, replicated line data, extracted word.
  - Reused by other future initiators.

Test Plan:
- Load 0x8000_0014 against the RAM model with 16-cycle delay, line word 1 = 0xDEADBEEF:
  - iomem addr=0x8000_0014, rw=0, held 17 cycles.
  - rsp_valid one cycle later with rdata=0xDEADBEEF, err=0.
- Store 0x8000_0028, wstrb=4'b0110, wdata=0x11223344:
  - rw=16'h0600, data=0x11223344 repeated ×4.
  - Response has rdata=0, and the line readback shows only bytes 9–10 changed.
- Load 0x3000_0004 (combinational responder), timer=0x0000_0005_0000_0009:
  - valid in the first REQ cycle, rdata=0x0000_0005.
  - Then one idle bus cycle before the next accept.
- Back-to-back loads with cli_req_valid_i held high:
  - cli_req_ready_o low from accept through RSP.
  - Exactly one rsp pulse per request; iomem valid low for ≥1 cycle between requests.
- IOMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder silent:
  - rsp at accept+9 with err=1, rdata=0.
  - Repeat with valid arriving on the 8th REQ cycle → err=0.
- rst_i asserted asynchronously mid-REQ:
  - iomem valid drops immediately with no rsp pulse; ready=1 on the first cycle after release.
